can_crc: RTL and testbench
==========================

Name: can_crc

Overview:
- Bit-serial CRC-15 generator/checker for the CAN 2.0 protocol layer.
- Sits beside the CAN bit-stream (de)serializer. It accumulates the CRC over SOF, arbitration, control and data bits, one bit per enabled clock.
- The transmitter appends crc_reg. The receiver compares crc_reg against the received CRC field, or feeds the CRC field through and checks for zero.

Parameters:
- CRC_WIDTH, 15, register width in bits. Fixed at 15 for CAN; other values are unsupported.
- CRC_POLY, 15'h4599, generator polynomial without the implicit x^15 term: x^15+x^14+x^10+x^8+x^7+x^4+x^3+1.
- CRC_INIT, 15'h0000, value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  1  serial data bit, MSB-first (bit-stream order), sampled on rising clk when enable=1.
- enable  input  1  bit-valid qualifier; 1 = ingest data_in this cycle.
- crc_reg  output  15  current CRC remainder, driven directly from the state register (registered output).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - rst=1 at a rising clk sets crc_reg = CRC_INIT (15'h0000) on that edge.
  - rst has priority over enable.
  - Asserting rst mid-message discards the accumulated value. The next enabled bit after release starts from 0.
- Update, per rising clk with rst=0 and enable=1:
  - fb = data_in XOR crc_reg[14]
  - crc_reg <= {crc_reg[13:0], 1'b0} XOR (fb ? CRC_POLY : 15'h0)
- Hold: with rst=0 and enable=0, crc_reg keeps its value indefinitely. The register is frozen for readout by the downstream framer or comparator.
- Latency:
  - Exactly one bit is absorbed per enabled edge.
  - crc_reg reflects that bit immediately after the same edge, with no pipeline delay.
  - There is no combinational path from data_in to crc_reg.
- Width: all arithmetic is 15-bit modulo-2. The bit shifted out of crc_reg[14] is discarded after forming fb.
- Inputs are sampled only at the rising edge. Values changed between edges have no effect until the next edge.
- No X propagation: crc_reg is defined from the first post-reset edge onward.
- Bit stuffing is out of scope. Stuff bits must be removed upstream (enable held low for stuff bits).
- Residue property: a message followed by its own 15-bit CRC (MSB first) yields crc_reg = 15'h0000.

Test Plan:
- Reset: hold rst=1 for 5 clocks with enable=1 and data_in toggling -> crc_reg = 15'h0000 throughout and after release.
- Single bit: after reset, one enabled cycle with data_in=1 -> crc_reg = 15'h4599.
- Byte stream: after reset, enable for 8 cycles with data_in = 0,1,0,1,1,0,1,0 (0x5A, MSB first) -> intermediate values:
  - 0000, 4599, 4EAB, 1D56, 7F35, 3BF3, 327F, final 15'h64FE.
- Hold: after the byte stream, deassert enable for 20 cycles with data_in random -> crc_reg stays 15'h64FE.
- Zero stream: after reset, 32 enabled cycles of data_in=0 -> crc_reg stays 15'h0000.
- Residue and reset-mid-op:
  - Feed 0x5A then CRC bits 110 0100 1111 1110 (15'h64FE, MSB first) -> crc_reg = 15'h0000.
  - Separately, assert rst for 1 cycle after bit 4 of the byte stream -> crc_reg = 0 next edge; resuming the stream from bit 1 reproduces 15'h64FE.

Source files
------------

// File: rtl/can_crc.sv
// Bit-serial CRC-15 generator/checker for the CAN protocol layer.
// The CRC is accumulated over SOF, arbitration, control and data bits (and the received CRC
// field when used as a checker), one bit per clock with enable high. Stuff bits must be
// removed upstream by holding enable low.
module can_crc #(
  // Only 15 is meaningful for CAN.
  parameter int unsigned             CRC_WIDTH = 15,
  // Generator polynomial without the implicit x^15 term.
  parameter logic [CRC_WIDTH-1:0]    CRC_POLY  = 15'h4599,
  parameter logic [CRC_WIDTH-1:0]    CRC_INIT  = 15'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic                 enable,
  output logic [CRC_WIDTH-1:0] crc_reg
);

  logic [CRC_WIDTH-1:0] r_crc;
  logic [CRC_WIDTH-1:0] w_crc_next;
  logic                 w_fb;

  // One LFSR step: the MSB shifted out is combined with the incoming bit to form the feedback.
  always_comb begin
    w_fb       = data_in ^ r_crc[CRC_WIDTH-1];
    w_crc_next = {r_crc[CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
  end

  // State register: reset wins over enable; with enable low the value is frozen for readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= CRC_INIT;
    end else if (enable) begin
      r_crc <= w_crc_next;
    end
  end

  assign crc_reg = r_crc;

endmodule

// File: tb/tb_can_crc.sv
// Directed self-checking bench for can_crc.
module tb_can_crc;

  logic        clk;
  logic        rst;
  logic        data_in;
  logic        enable;
  logic [14:0] crc_reg;

  int n_tests;
  int n_fail;

  can_crc #(
    .CRC_WIDTH(15),
    .CRC_POLY (15'h4599),
    .CRC_INIT (15'h0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .enable (enable),
    .crc_reg(crc_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs mid-low-phase, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic d);
    @(negedge clk);
    rst     = r;
    enable  = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [14:0] exp);
    n_tests++;
    assert (crc_reg === exp)
    else begin
      n_fail++;
      $error("FAIL %s: crc_reg=%h expected=%h", tag, crc_reg, exp);
    end
  endtask

  logic [7:0]  msg_byte;
  logic [14:0] crc_bits;
  logic [14:0] exp_byte [8];

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    data_in  = 1'b0;
    msg_byte = 8'h5A;
    crc_bits = 15'h64FE;
    exp_byte = '{15'h0000, 15'h4599, 15'h4EAB, 15'h1D56,
                 15'h7F35, 15'h3BF3, 15'h327F, 15'h64FE};

    // Reset held with enable high and toggling data: must stay at zero.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, i[0]);
      check("reset_hold", 15'h0000);
    end
    step(1'b0, 1'b0, 1'b1);
    check("reset_release", 15'h0000);

    // Single 1 bit from zero loads the polynomial.
    step(1'b0, 1'b1, 1'b1);
    check("single_bit", 15'h4599);

    // Byte 0x5A, MSB first, with every intermediate remainder checked.
    step(1'b1, 1'b0, 1'b0);
    check("reset_before_byte", 15'h0000);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, msg_byte[7-i]);
      check($sformatf("byte_bit%0d", i), exp_byte[i]);
    end

    // Hold with random data and enable low.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      check("hold", 15'h64FE);
    end

    // Zero stream from reset stays at zero.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b0);
    end
    check("zero_stream", 15'h0000);

    // Residue: message followed by its own CRC yields zero.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, msg_byte[7-i]);
    end
    check("residue_msg", 15'h64FE);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, crc_bits[14-i]);
    end
    check("residue_zero", 15'h0000);

    // Reset mid-message discards state; restarting the byte reproduces the same CRC.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, msg_byte[7-i]);
    end
    check("mid_before_rst", 15'h1D56);
    step(1'b1, 1'b1, 1'b1);
    check("mid_rst", 15'h0000);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, msg_byte[7-i]);
    end
    check("mid_resume", 15'h64FE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
